muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide sequencer owning the HI/LO register pair for the pipelined MIPS core. It sits beside the single-cycle ALU in EX. It accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a 32-step shift-add or restoring-divide loop over an internal 32-bit adder. It raises `busy` so the hazard logic stalls MFHI/MFLO and further mult/div ops until HI/LO are valid.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Only 32 is supported; the iteration counter is log2(WIDTH) bits.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request a new operation; sampled only when `busy`=0.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `A`  in  32  rs operand (multiplicand / dividend), captured on accept.
- `B`  in  32  rt operand (multiplier / divisor), captured on accept.
- `mthi`, `mtlo`  in  1 each  write `wdata` to HI / LO.
- `wdata`  in  32  MTHI/MTLO data.
- `flush`  in  1  abort the in-flight operation (pipeline squash).
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `div_zero`  out  1  valid with `done`; set when a DIV/DIVU had B=0.
- `hi`, `lo`  out  32  architectural HI/LO registers.

## Operation
- **States:** IDLE, PREP, RUN, FIX.
- **IDLE:**
  - `start`=1 and `flush`=0: latch op, A and B, then go to PREP.
  - Signed ops: record the result sign and the dividend sign.
- **PREP:**
  - Signed ops: replace A and B by their magnitudes (|0x80000000| = 2^31 as unsigned).
  - Clear the 64-bit accumulator; counter = 0; go to RUN.
- **RUN, one step per cycle for 32 cycles:**
  - Multiply: conditional add of B into the upper half, then shift right.
  - Divide: restoring step: shift the remainder left, trial-subtract B, keep it if non-negative, shift the quotient bit in.
  - Exit to FIX when the counter reaches 31. The counter wraps to 0 and is not reused.
- **FIX, then IDLE:**
  - Apply sign correction and write HI/LO. Pulse `done`.
  - Multiply result: HI = upper 32 bits, LO = lower 32 bits of the 64-bit product.
  - Divide result: LO = quotient, truncated toward zero. HI = remainder; its sign follows the dividend.
- **Divide by zero:** HI = original A, LO = 0xFFFFFFFF, `div_zero`=1. Applies to signed and unsigned.
- **Signed overflow:** 0x80000000 / -1 gives LO = 0x80000000, HI = 0.
- **MTHI/MTLO:** write on the clock edge when `busy`=0. Ignored while `busy`=1.
- **MTHI/MTLO together with `start` in IDLE:** both take effect. The later result overwrites HI/LO.
- **`start` while busy:** ignored; no queueing.
- **`flush`:**
  - In PREP, RUN or FIX: next state IDLE. No HI/LO write, no `done`.
  - In IDLE: suppresses a same-cycle `start`.
  - Flush in FIX wins over the write.
- **`reset`:** state IDLE; `hi`=`lo`=0; `busy`=`done`=`div_zero`=0. Applies immediately, including mid-operation.

## Timing
- Accept edge = E0. State after each edge:
  - E0: PREP.
  - E1 to E32: RUN, counter 0..31.
  - E33: FIX.
  - E34: IDLE.
- `busy`=1 for exactly 34 cycles: the cycles following E0 through E33.
- `busy` is registered. It goes high in the cycle after the accept edge, so the hazard unit must also decode `start` combinationally for that first cycle.
- HI/LO update at E34. `done` (and `div_zero`, when set) are high for the single cycle after E34; `busy`=0 in that cycle.
- A new `start` may be accepted in the `done` cycle, i.e. back-to-back operations at a 35-cycle period.
- `hi`/`lo` are direct register outputs with no combinational path from inputs. MTHI/MTLO results are visible the cycle after the write edge.

## Structure
- **Package `muldiv_pkg`:** `op` encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU; the state enum; the localparam for step count (32).
- **One sub-module, `muldiv_step`:** combinational single iteration. Inputs: accumulator, B, mode. Outputs: next accumulator. Reusable for a future 2-steps-per-cycle variant.
- **Controller:** FSM, counter, sign bookkeeping and HI/LO registers in `muldiv_unit`.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; `done` exactly 35 cycles after the start cycle.
- MULT A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=0 -> HI=0x00000064, LO=0xFFFFFFFF, `div_zero`=1 in the `done` cycle. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- After HI=0x11111111, LO=0x22222222: start DIVU, assert `flush` 10 cycles later -> `busy`=0 the next cycle, no `done`, HI/LO unchanged.
- During RUN: pulse `start` with new operands and assert `mthi` with 0xDEADBEEF -> both ignored; the original result is written.
- Assert `reset` mid-RUN -> all outputs 0 immediately. A new MULTU 3×4 afterwards gives LO=12, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - md_op_e    : EX-stage operation encodings (MULT/MULTU/DIV/DIVU)
//   - md_state_e : sequencer states
//   - MD_STEPS   : number of iteration steps per operation
//   - helpers that classify an operation as signed and/or divide
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int MD_STEPS = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Bundle between the EX stage (master) and the multiply/divide unit (slave).
//   start/op/A/B   : operation request and operands (sampled when not busy)
//   mthi/mtlo/wdata: direct writes to HI/LO
//   flush          : pipeline squash of the in-flight operation
//   busy/done/div_zero/hi/lo : status and architectural HI/LO registers
// -----------------------------------------------------------------------------
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B, mthi, mtlo, wdata, flush,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, A, B, mthi, mtlo, wdata, flush,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the multiply/divide loop.
//   acc_i : 64-bit accumulator {upper, lower}
//   b_i   : multiplicand (multiply) or divisor (divide), unsigned magnitude
//   div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_o : accumulator after the step
// Multiply: lower half holds the remaining multiplier bits; when its LSB is
// set, b_i is added into the upper half, then the whole thing (including the
// carry) shifts right by one.
// Divide: upper half is the partial remainder, lower half shifts the dividend
// out at the top and the quotient bits in at the bottom.
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               div_i,
    output logic [2*WIDTH-1:0] acc_o
);
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, b_i} : '0);
        // Remainder shifted left with the next dividend bit; needs one extra
        // bit because the remainder can be as large as b_i-1.
        rem_sh  = acc_i[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, b_i};
        if (div_i) begin
            // diff[WIDTH] is the borrow: set means the trial subtract failed.
            if (!diff[WIDTH]) begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {mul_sum, acc_i[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide sequencer owning the HI/LO register pair.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; returns to IDLE and clears HI/LO
//   bus   : muldiv_if slave (request, MTHI/MTLO, flush, status, HI/LO)
// Sequence: IDLE -accept-> PREP (take magnitudes) -> RUN (32 steps) -> FIX
// (sign correction, HI/LO write, done pulse) -> IDLE. busy is high from the
// cycle after the accept edge through the FIX cycle. Only WIDTH=32 is used.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    md_op_e             op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;          // original A, kept for div-by-zero
    logic [WIDTH-1:0]   b_q, b_d;          // B, replaced by |B| in PREP
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               res_neg_q, res_neg_d;  // product / quotient negative
    logic               rem_neg_q, rem_neg_d;  // dividend negative
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i (acc_q),
        .b_i   (b_q),
        .div_i (md_is_div(op_q)),
        .acc_o (step_acc)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;

        // Magnitudes; -0x80000000 wraps to 0x80000000 which is 2^31 unsigned.
        a_mag = (md_is_signed(op_q) && a_q[WIDTH-1]) ? -a_q : a_q;
        b_mag = (md_is_signed(op_q) && b_q[WIDTH-1]) ? -b_q : b_q;
        prod  = res_neg_q ? -acc_q : acc_q;
        quo   = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem   = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        unique case (state_q)
            ST_IDLE: begin
                // Direct writes land first; a result started now overwrites
                // them later anyway.
                if (bus.mthi) hi_d = bus.wdata;
                if (bus.mtlo) lo_d = bus.wdata;
                if (bus.start && !bus.flush) begin
                    op_d      = md_op_e'(bus.op);
                    a_d       = bus.A;
                    b_d       = bus.B;
                    res_neg_d = md_is_signed(md_op_e'(bus.op)) &&
                                (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    rem_neg_d = md_is_signed(md_op_e'(bus.op)) && bus.A[WIDTH-1];
                    state_d   = ST_PREP;
                end
            end
            ST_PREP: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    // Upper half cleared; lower half carries the multiplier
                    // or dividend bits consumed by the step.
                    acc_d   = {{WIDTH{1'b0}}, a_mag};
                    b_d     = b_mag;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MD_STEPS - 1)) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (md_is_div(op_q)) begin
                        if (b_q == '0) begin
                            hi_d = a_q;
                            lo_d = '1;
                            dz_d = 1'b1;
                        end else begin
                            hi_d = rem;
                            lo_d = quo;
                        end
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= MD_MULT;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed vectors for muldiv_unit. A behavioural model (plain 64-bit integer
// arithmetic plus a busy-cycle countdown) predicts HI/LO/busy/done/div_zero
// every cycle; directed steps also check hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    function automatic void model_result(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b, output logic [31:0] rh,
                                         output logic [31:0] rl, output logic rdz);
        longint sa, sb, q, r;
        logic [63:0] p;
        rdz = 1'b0;
        rh  = '0;
        rl  = '0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        case (o)
            2'b00: begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; rh = p[63:32]; rl = p[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    rh = a; rl = 32'hFFFF_FFFF; rdz = 1'b1;
                end else if (o == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    rl = q[31:0]; rh = r[31:0];
                end else begin
                    rl = a / b; rh = a % b;
                end
            end
        endcase
    endfunction

    logic [31:0] nxt_hi, nxt_lo;
    logic        nxt_dz;
    always_comb model_result(bus.op, bus.A, bus.B, nxt_hi, nxt_lo, nxt_dz);

    int          m_cnt;      // busy cycles still to go; 0 = idle
    logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
    logic        m_res_dz, m_done, m_dz;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dz <= 1'b0;
            m_res_hi <= '0; m_res_lo <= '0; m_res_dz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_cnt == 0) begin
                if (bus.mthi) m_hi <= bus.wdata;
                if (bus.mtlo) m_lo <= bus.wdata;
                if (bus.start && !bus.flush) begin
                    m_res_hi <= nxt_hi; m_res_lo <= nxt_lo; m_res_dz <= nxt_dz;
                    m_cnt    <= 34;
                end
            end else if (bus.flush) begin
                m_cnt <= 0;
            end else if (m_cnt == 1) begin
                m_hi <= m_res_hi; m_lo <= m_res_lo;
                m_done <= 1'b1; m_dz <= m_res_dz;
                m_cnt <= 0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_busy", {31'b0, bus.busy}, {31'b0, m_cnt != 0});
        check("cyc_done", {31'b0, bus.done}, {31'b0, m_done});
        check("cyc_dz",   {31'b0, bus.div_zero}, {31'b0, m_dz});
        check("cyc_hi",   bus.hi, m_hi);
        check("cyc_lo",   bus.lo, m_lo);
    end

    // ---------------- directed stimulus ----------------
    // mode 0: plain; 1: start+MTHI pulse mid-RUN; 2: MTHI together with start
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int mode);
        int n;
        bit seen;
        bus.op = o; bus.A = a; bus.B = b; bus.start = 1'b1;
        if (mode == 2) begin bus.mthi = 1'b1; bus.wdata = 32'h5555_5555; end
        n = 0; seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            bus.start = 1'b0;
            bus.mthi  = 1'b0;
            if (mode == 2 && n == 1) check({name, "_mthi_with_start"}, bus.hi, 32'h5555_5555);
            if (mode == 1 && n == 5) begin
                bus.start = 1'b1; bus.A = 32'd99; bus.B = 32'd99;
                bus.mthi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
            end
            if (bus.done) seen = 1'b1;
        end
        check({name, "_done_seen"}, {31'b0, seen}, 32'd1);
        check({name, "_latency"}, n, 32'd35);
        check({name, "_hi"}, bus.hi, ehi);
        check({name, "_lo"}, bus.lo, elo);
        check({name, "_dz"}, {31'b0, bus.div_zero}, {31'b0, edz});
        $display("op %-10s A=%08h B=%08h -> hi=%08h lo=%08h dz=%0b cycles=%0d",
                 name, a, b, bus.hi, bus.lo, bus.div_zero, n);
    endtask

    initial begin
        bit any_done;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back operations: each starts in the previous done cycle.
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
        run_op("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
        run_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("divu_zero", MD_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 0);
        run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0);
        run_op("divu_7",    MD_DIVU,  32'd1000,      32'd7,         32'h0000_0006, 32'h0000_008E, 1'b0, 0);
        run_op("div_negb",  MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("div_zero_s",MD_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 0);
        run_op("mult_min",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 2);
        run_op("multu_dist",MD_MULTU, 32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A, 1'b0, 1);

        // Flush mid-divide leaves HI/LO untouched.
        @(negedge clk);
        bus.mthi = 1'b1; bus.wdata = 32'h1111_1111;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = 32'h2222_2222;
        @(negedge clk);
        bus.mtlo = 1'b0;
        check("mt_hi", bus.hi, 32'h1111_1111);
        check("mt_lo", bus.lo, 32'h2222_2222);
        bus.op = MD_DIVU; bus.A = 32'd1000; bus.B = 32'd7; bus.start = 1'b1;
        repeat (10) begin @(negedge clk); bus.start = 1'b0; end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", {31'b0, bus.busy}, 32'd0);
        any_done = 1'b0;
        repeat (40) begin @(negedge clk); if (bus.done) any_done = 1'b1; end
        check("flush_no_done", {31'b0, any_done}, 32'd0);
        check("flush_hi", bus.hi, 32'h1111_1111);
        check("flush_lo", bus.lo, 32'h2222_2222);
        $display("op flush      hi=%08h lo=%08h", bus.hi, bus.lo);

        // Asynchronous reset mid-RUN clears everything immediately.
        bus.op = MD_MULTU; bus.A = 32'h1234; bus.B = 32'h5678; bus.start = 1'b1;
        repeat (12) begin @(negedge clk); bus.start = 1'b0; end
        #2 reset = 1'b1;
        #1;
        check("arst_hi", bus.hi, 32'h0);
        check("arst_lo", bus.lo, 32'h0);
        check("arst_busy", {31'b0, bus.busy}, 32'd0);
        check("arst_done", {31'b0, bus.done}, 32'd0);
        $display("op reset      hi=%08h lo=%08h busy=%0b", bus.hi, bus.lo, bus.busy);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op("multu_3x4", MD_MULTU, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
